// File: rtl/hex_mux_scan_pkg.sv
// ---------------------------------------------------------------------------
// hex_mux_scan_pkg
// Shared definitions for the multiplexed seven-segment scanner:
//   - SEG_BLANK / SEG_OFF  : all segments (and dp) dark, active-low
//   - SEG_TABLE            : 16-entry hex glyph table, seg[6:0] = gfedcba
//   - nibble_to_seg()      : glyph lookup for one 4-bit digit
//   - scan_phase_e         : phase of the per-slot output sequencer
// ---------------------------------------------------------------------------
package hex_mux_scan_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  // Active-low glyphs for 0..9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Output sequencer phase: dark until the first slot tick after reset,
  // one gap cycle after every tick, then the digit is shown for the rest
  // of the slot.
  typedef enum logic [1:0] {
    PH_DARK = 2'd0,
    PH_GAP  = 2'd1,
    PH_SHOW = 2'd2
  } scan_phase_e;

  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_mux_scan_sync.sv
// ---------------------------------------------------------------------------
// hex_mux_scan_sync
// Two-flop synchroniser for a slow asynchronous bus (switch inputs).
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset, clears both stages
//   d_in   : asynchronous input bus
//   q_out  : synchronised bus, two clk cycles of latency
// ---------------------------------------------------------------------------
module hex_mux_scan_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/hex_mux_scan.sv
// ---------------------------------------------------------------------------
// hex_mux_scan
// Selects one of CH_NUM hex channels, snapshots it once per display frame
// and scans it onto a multiplexed common-anode seven-segment display.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   sel         : channel select from switches (asynchronous, synchronised)
//   ch_data     : channel c digit d nibble at [(c*DIGITS+d)*4 +: 4]
//   ch_valid    : per-channel valid; invalid channels are not snapshotted
//   blank_zero  : suppress leading zero digits (digit 0 always shown)
//   dp_mask     : per-digit decimal point enable, active-high
//   seg         : active-low segments, [6:0]=gfedcba, [7]=dp (registered)
//   dig_en      : active-low digit enables, at most one low (registered)
//   mux_out     : frame snapshot of the selected channel
//   sel_err     : synchronised select was out of range at last frame tick
// ---------------------------------------------------------------------------
module hex_mux_scan
  import hex_mux_scan_pkg::*;
#(
  parameter int CH_NUM   = 4,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(CH_NUM)-1:0]    sel,
  input  logic [CH_NUM*DIGITS*4-1:0]   ch_data,
  input  logic [CH_NUM-1:0]            ch_valid,
  input  logic                         blank_zero,
  input  logic [DIGITS-1:0]            dp_mask,
  output logic [7:0]                   seg,
  output logic [DIGITS-1:0]            dig_en,
  output logic [DIGITS*4-1:0]          mux_out,
  output logic                         sel_err
);

  localparam int SEL_W   = $clog2(CH_NUM);
  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int WORD_W  = DIGITS * 4;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [SEL_W:0]     CH_LIMIT  = (SEL_W + 1)'(CH_NUM);

  // Synchronised select
  logic [SEL_W-1:0] sel_s;

  hex_mux_scan_sync #(
    .WIDTH (SEL_W)
  ) u_sel_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (sel),
    .q_out (sel_s)
  );

  // State
  logic [PRESC_W-1:0] presc_q,  presc_d;
  logic [IDX_W-1:0]   idx_q,    idx_d;
  logic [WORD_W-1:0]  mux_q,    mux_d;
  logic               sel_err_q, sel_err_d;
  logic [7:0]         seg_q,    seg_d;
  logic [DIGITS-1:0]  dig_en_q, dig_en_d;
  scan_phase_e        phase_q,  phase_d;

  // Combinational helpers
  logic               tick;
  logic               frame_tick;
  logic               sel_ok;
  logic [WORD_W-1:0]  chan_word;
  logic               chan_valid;
  logic [DIGITS-1:0]  lz_blank;
  logic               higher_zero;
  logic [3:0]         cur_nib;
  logic               cur_dp;
  logic               cur_lz;
  logic [DIGITS-1:0]  cur_dig_en;

  // Slot/frame timing: a tick on the prescaler wrap cycle, and the frame
  // tick is the slot tick that brings the digit index back to 0.
  always_comb begin
    tick       = (presc_q == PRESC_MAX);
    frame_tick = tick && (idx_q == IDX_LAST);
  end

  // Channel selection. Matching by loop keeps an out-of-range select from
  // indexing past ch_data / ch_valid; it simply matches nothing.
  always_comb begin
    sel_ok     = ({1'b0, sel_s} < CH_LIMIT);
    chan_word  = '0;
    chan_valid = 1'b0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (sel_s == SEL_W'(c)) begin
        chan_word  = ch_data[c*WORD_W +: WORD_W];
        chan_valid = ch_valid[c];
      end
    end
  end

  // Leading-zero map: a digit is suppressible when it and every higher
  // digit of the snapshot are zero; digit 0 is never suppressed.
  always_comb begin
    lz_blank    = '0;
    higher_zero = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      higher_zero = higher_zero && (mux_q[d*4 +: 4] == 4'h0);
      lz_blank[d] = blank_zero && higher_zero && (d != 0);
    end
  end

  // Attributes of the digit at the current scan index.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    cur_dig_en = '1;
    for (int d = 0; d < DIGITS; d++) begin
      if (idx_q == IDX_W'(d)) begin
        cur_nib       = mux_q[d*4 +: 4];
        cur_dp        = dp_mask[d];
        cur_lz        = lz_blank[d];
        cur_dig_en[d] = 1'b0;
      end
    end
  end

  // Prescaler, scan index, frame snapshot and select error.
  always_comb begin
    presc_d   = presc_q + PRESC_W'(1);
    idx_d     = idx_q;
    mux_d     = mux_q;
    sel_err_d = sel_err_q;
    if (tick) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    if (frame_tick) begin
      sel_err_d = !sel_ok;
      if (sel_ok && chan_valid) begin
        mux_d = chan_word;
      end
    end
  end

  // Output sequencer next state.
  always_comb begin
    phase_d = phase_q;
    if (tick) begin
      phase_d = PH_GAP;
    end else if (phase_q == PH_GAP) begin
      phase_d = PH_SHOW;
    end
  end

  // Output drive. The display word is computed once, on the cycle after
  // the gap, and then held for the whole slot so that input changes inside
  // a slot can never glitch the segments; dp_mask and blank_zero therefore
  // land at the next slot.
  always_comb begin
    seg_d    = seg_q;
    dig_en_d = dig_en_q;
    if (tick) begin
      seg_d    = SEG_BLANK;
      dig_en_d = '1;
    end else if (phase_q == PH_GAP) begin
      dig_en_d = cur_dig_en;
      if (sel_err_q) begin
        seg_d = SEG_BLANK;
      end else if (cur_lz) begin
        seg_d = {~cur_dp, SEG_OFF};
      end else begin
        seg_d = {~cur_dp, nibble_to_seg(cur_nib)};
      end
    end
  end

  // State registers; reset drops any partially built frame immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      mux_q     <= '0;
      sel_err_q <= 1'b0;
      seg_q     <= SEG_BLANK;
      dig_en_q  <= '1;
      phase_q   <= PH_DARK;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      mux_q     <= mux_d;
      sel_err_q <= sel_err_d;
      seg_q     <= seg_d;
      dig_en_q  <= dig_en_d;
      phase_q   <= phase_d;
    end
  end

  assign seg     = seg_q;
  assign dig_en  = dig_en_q;
  assign mux_out = mux_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_hex_mux_scan.sv
// ---------------------------------------------------------------------------
// tb_hex_mux_scan
// Directed plus randomised checks of hex_mux_scan (CH_NUM=3, DIGITS=4,
// SCAN_DIV=4) against a cycle-count based reference model: the model knows
// only "edge n after reset release", from which it derives slot number,
// digit number, gap cycles and frame boundaries arithmetically.
// ---------------------------------------------------------------------------
module tb_hex_mux_scan;

  localparam int CH_NUM   = 3;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = SCAN_DIV * DIGITS;

  localparam logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [47:0] ch_data = '0;
  logic [2:0]  ch_valid = '0;
  logic        blank_zero = 1'b0;
  logic [3:0]  dp_mask = '0;
  logic [7:0]  seg;
  logic [3:0]  dig_en;
  logic [15:0] mux_out;
  logic        sel_err;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;

  // Reference model state
  logic [1:0]  sel_log [$];
  logic [15:0] m_mux = '0;
  logic        m_err = 1'b0;
  logic [7:0]  exp_seg = 8'hFF;
  logic [3:0]  exp_dig = 4'hF;

  hex_mux_scan #(
    .CH_NUM   (CH_NUM),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel        (sel),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .blank_zero (blank_zero),
    .dp_mask    (dp_mask),
    .seg        (seg),
    .dig_en     (dig_en),
    .mux_out    (mux_out),
    .sel_err    (sel_err)
  );

  always #5 clk = ~clk;

  // Expected segment word for digit d of the current model snapshot.
  function automatic logic [7:0] segFor(input int d);
    logic [3:0] nib;
    logic [6:0] s7;
    if (m_err) return 8'hFF;
    nib = 4'((m_mux >> (4 * d)) & 16'hF);
    if (blank_zero && d != 0 && (m_mux >> (4 * d)) == 16'h0) s7 = 7'h7F;
    else s7 = SEG_REF[nib];
    return {~dp_mask[d], s7};
  endfunction

  // Update the model for rising edge number n since reset release.
  task automatic modelEdge();
    int s;
    int d;
    if (n % SCAN_DIV == 0) begin
      if ((n / SCAN_DIV) % DIGITS == 0) begin
        // select seen two edges earlier through the synchroniser
        s = (n >= 3) ? int'(sel_log[n-3]) : 0;
        m_err = (s >= CH_NUM);
        if (s < CH_NUM && ch_valid[s]) m_mux = ch_data[s*16 +: 16];
      end
      exp_seg = 8'hFF;
      exp_dig = 4'hF;
    end else if (n % SCAN_DIV == 1 && n > SCAN_DIV) begin
      d = (n / SCAN_DIV) % DIGITS;
      exp_dig    = 4'hF;
      exp_dig[d] = 1'b0;
      exp_seg    = segFor(d);
    end
  endtask

  task automatic checkValue(input string tag, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("[TB] FAIL %s at edge %0d: observed %h expected %h", tag, n, got, want);
    end
  endtask

  task automatic checkOutput();
    checkValue("seg",     {8'h0, seg},     {8'h0, exp_seg});
    checkValue("dig_en",  {12'h0, dig_en}, {12'h0, exp_dig});
    checkValue("mux_out", mux_out,         m_mux);
    checkValue("sel_err", {15'h0, sel_err}, {15'h0, m_err});
  endtask

  // One clock cycle: record the select present at this edge, clock,
  // advance the model and compare.
  task automatic applyStimulus();
    sel_log.push_back(sel);
    @(posedge clk);
    #1;
    n++;
    modelEdge();
    checkOutput();
  endtask

  task automatic runCycles(input int k);
    for (int i = 0; i < k; i++) applyStimulus();
  endtask

  task automatic runToFrame();
    int guard;
    guard = 0;
    applyStimulus();
    while (n % FRAME != 0 && guard < 2 * FRAME) begin
      applyStimulus();
      guard++;
    end
    checkValue("frame_align", 16'(n % FRAME), 16'h0);
  endtask

  // Assert reset mid-slot, check the asynchronous clear, then release
  // #1 after a rising edge so the next edge is edge 1.
  task automatic pulseReset();
    rst_n = 1'b0;
    #2;
    m_mux = '0; m_err = 1'b0; exp_seg = 8'hFF; exp_dig = 4'hF;
    checkOutput();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;
    n = 0;
    sel_log.delete();
  endtask

  task automatic randomChange();
    logic [15:0] w;
    int c;
    case ($urandom_range(0, 4))
      0: sel = 2'($urandom_range(0, 3));
      1: begin
        c = $urandom_range(0, CH_NUM - 1);
        w = 16'($urandom);
        w = w >> (4 * $urandom_range(0, 4));
        ch_data[c*16 +: 16] = w;
      end
      2: ch_valid = 3'($urandom);
      3: blank_zero = 1'($urandom);
      default: dp_mask = 4'($urandom);
    endcase
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    checkOutput();
    checkValue("reset_seg", {8'h0, seg}, 16'h00FF);
    checkValue("reset_dig", {12'h0, dig_en}, 16'h000F);

    ch_data  = {16'h5678, 16'h00A0, 16'h1234};
    ch_valid = 3'b111;
    sel      = 2'd0;
    rst_n    = 1'b1;
    n        = 0;

    // ch0 = 1234: first frame, then a displayed frame
    runToFrame();
    checkValue("first_frame_mux", mux_out, 16'h1234);
    runToFrame();

    // ch1 = 00A0 with and without leading-zero suppression
    sel = 2'd1;
    blank_zero = 1'b1;
    runToFrame();
    checkValue("ch1_mux", mux_out, 16'h00A0);
    runToFrame();
    blank_zero = 1'b0;
    runToFrame();

    // Select switched mid-frame: snapshot only moves at the frame tick
    sel = 2'd0;
    runToFrame();
    runToFrame();
    runCycles(6);
    sel = 2'd1;
    runCycles(FRAME - 6 - 1);
    checkValue("midframe_hold", mux_out, 16'h1234);
    applyStimulus();
    checkValue("midframe_load", mux_out, 16'h00A0);
    runToFrame();

    // Out-of-range select, then recovery on channel 2
    sel = 2'd3;
    runToFrame();
    checkValue("sel_err_set", {15'h0, sel_err}, 16'h0001);
    checkValue("sel_err_hold", mux_out, 16'h00A0);
    runToFrame();
    sel = 2'd2;
    runToFrame();
    checkValue("sel_err_clr", {15'h0, sel_err}, 16'h0000);
    runToFrame();

    // Invalid channel keeps the old snapshot; decimal point on digit 1
    sel = 2'd0;
    ch_valid = 3'b110;
    ch_data[15:0] = 16'h9ABC;
    dp_mask = 4'b0010;
    runToFrame();
    checkValue("invalid_hold", mux_out, 16'h5678);
    runToFrame();
    // dp_mask change in the middle of a slot is deferred to the next slot
    runCycles(6);
    dp_mask = 4'b1001;
    runCycles(FRAME);

    // Randomised traffic
    for (int i = 0; i < 480; i++) begin
      if ($urandom_range(0, 5) == 0) randomChange();
      applyStimulus();
    end

    // Reset mid-slot and rescan from index 0
    runToFrame();
    runCycles(6);
    pulseReset();
    sel = 2'd2;
    ch_valid = 3'b111;
    runToFrame();
    runToFrame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
